// File: rtl/ift_taint_monitor.sv
// Observes an IFT-instrumented flip-flop output (Q, Q_t) for a programmed number of cycles
// and hands back one taint summary per ARM over a valid/ready handshake.
module ift_taint_monitor #(
  parameter int WIDTH = 2,
  parameter int TW    = 32,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             SRST,
  input  logic             ARM,
  input  logic [CNT_W-1:0] WINDOW,
  input  logic [WIDTH-1:0] Q,
  input  logic [TW-1:0]    Q_t,
  output logic             BUSY,
  output logic             REPORT_VALID,
  input  logic             REPORT_READY,
  output logic             TAINT_SEEN,
  output logic [TW-1:0]    TAINT_ACC,
  output logic [CNT_W-1:0] TAINT_CNT,
  output logic [CNT_W-1:0] FIRST_CYC,
  output logic [WIDTH-1:0] FIRST_Q
);

  typedef enum logic [1:0] {IDLE, MONITOR, REPORT} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] win, cyc;
  logic             tainted, last_sample;

  // Case inequality so an unknown taint label counts as tainted in simulation.
  assign tainted     = (Q_t !== '0);
  assign last_sample = (cyc == win - CNT_W'(1));

  assign BUSY         = (state != IDLE);
  assign REPORT_VALID = (state == REPORT);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ARM) state_nxt = (WINDOW != '0) ? MONITOR : REPORT;
      MONITOR: if (last_sample) state_nxt = REPORT;
      REPORT:  if (REPORT_READY) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (SRST) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge CLK) begin
    if (SRST) begin
      win        <= '0;
      cyc        <= '0;
      TAINT_SEEN <= 1'b0;
      TAINT_ACC  <= '0;
      TAINT_CNT  <= '0;
      FIRST_CYC  <= '0;
      FIRST_Q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ARM) begin
            win        <= WINDOW;
            cyc        <= '0;
            TAINT_SEEN <= 1'b0;
            TAINT_ACC  <= '0;
            TAINT_CNT  <= '0;
            FIRST_CYC  <= '0;
            FIRST_Q    <= '0;
          end
        end
        MONITOR: begin
          if (tainted) begin
            TAINT_ACC <= TAINT_ACC | Q_t;
            if (TAINT_CNT != '1) TAINT_CNT <= TAINT_CNT + CNT_W'(1);
            if (!TAINT_SEEN) begin
              TAINT_SEEN <= 1'b1;
              FIRST_CYC  <= cyc;
              FIRST_Q    <= Q;
            end
          end
          if (!last_sample) cyc <= cyc + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/ift_taint_monitor.md
Name: ift_taint_monitor

Overview:
- Downstream consumer of an IFT-instrumented enable/sync-reset flip-flop stage (m_0 style, data Q plus 32-bit taint Q_t).
- Watches Q/Q_t over a programmable window of CLK cycles and accumulates taint statistics: label union, count of tainted samples, and the cycle and value of the first tainted sample.
- Returns a one-shot report over a valid/ready handshake, so the flip-flop's taint propagation can be checked in simulation and in hardware.

Parameters:
- WIDTH, 2, data width of the monitored Q.
- TW, 32, taint label width of Q_t.
- CNT_W, 16, width of the window, cycle and count fields.

Ports:
- CLK  input  1  clock, rising edge.
- SRST  input  1  synchronous, active-high reset.
- ARM  input  1  start a monitoring window; honoured in IDLE only.
- WINDOW  input  CNT_W  window length in cycles; latched on an accepted ARM.
- Q  input  WIDTH  data from the upstream flip-flop.
- Q_t  input  TW  taint of Q; any nonzero bit means tainted.
- BUSY  output  1  high in MONITOR and REPORT.
- REPORT_VALID  output  1  report fields are valid.
- REPORT_READY  input  1  consumer accepts the report.
- TAINT_SEEN  output  1  at least one tainted sample in the window.
- TAINT_ACC  output  TW  bitwise OR of all Q_t sampled in the window.
- TAINT_CNT  output  CNT_W  number of tainted samples, saturating.
- FIRST_CYC  output  CNT_W  window cycle index (0-based) of the first tainted sample.
- FIRST_Q  output  WIDTH  Q captured at the first tainted sample.

Behaviour:
- Reset:
  - SRST=1 at a rising CLK edge forces state=IDLE.
  - All outputs clear to 0, and the internal cycle counter and latched window clear to 0.
  - SRST has priority over every other input, in any state, including mid-window and mid-handshake.
- State IDLE:
  - BUSY=0, REPORT_VALID=0.
  - ARM=1 at an edge: latch WINDOW into win, clear cyc, TAINT_SEEN, TAINT_ACC, TAINT_CNT, FIRST_CYC and FIRST_Q.
  - Go to MONITOR if WINDOW!=0.
  - Go directly to REPORT if WINDOW=0; this is an empty report with all fields 0.
- State MONITOR, at each edge (one sample per cycle, first sample on the edge after ARM):
  - If Q_t!=0:
    - TAINT_ACC |= Q_t.
    - TAINT_CNT += 1, saturating at 2^CNT_W-1.
    - If TAINT_SEEN==0: FIRST_CYC<=cyc, FIRST_Q<=Q, TAINT_SEEN<=1.
  - If cyc==win-1: go to REPORT; otherwise cyc+=1.
  - ARM is ignored.
- Latency: an effect of a sample taken at edge k is visible on the outputs after edge k.
- State REPORT:
  - REPORT_VALID=1; all report fields are held stable while REPORT_VALID=1 and REPORT_READY=0.
  - Q and Q_t are ignored.
  - On an edge with REPORT_VALID & REPORT_READY: go to IDLE. Report fields keep their values until the next accepted ARM.
  - ARM in the same cycle as the accepting handshake is ignored; the next ARM is honoured in IDLE.
- Window: exactly win samples per window. WINDOW changes after ARM have no effect.
- X on Q_t is treated as tainted in simulation (case inequality); synthesis has no special handling.

Test Plan:
- Reset mid-window: ARM with WINDOW=8, apply Q_t=1 for 3 cycles, assert SRST for one cycle -> next cycle state IDLE, BUSY=0 and all outputs 0.
- Clean window: ARM with WINDOW=4, Q_t=0 throughout, Q cycling 00,01,10,11 -> REPORT_VALID rises after the 4th sample, TAINT_SEEN=0, TAINT_ACC=0, TAINT_CNT=0.
- Mixed labels:
  - ARM with WINDOW=6, Q_t sequence 0,0,0x4,0,0x1,0x4, Q=10 at cycle index 2.
  - Expect TAINT_SEEN=1, TAINT_ACC=0x5, TAINT_CNT=3, FIRST_CYC=2, FIRST_Q=10.
- Backpressure: report ready with REPORT_READY=0 for 5 cycles while Q_t toggles -> fields and REPORT_VALID stay stable. Then REPORT_READY=1 -> IDLE on the next edge and BUSY=0.
- Boundaries:
  - WINDOW=0 -> REPORT in the cycle after ARM with all fields 0.
  - WINDOW=1 with Q_t=0x80000000 -> TAINT_CNT=1, FIRST_CYC=0.
  - CNT_W=2 build, WINDOW=3: the window ends after 3 samples as specified.
- Flip-flop chain: drive the upstream sdffe with D_t=0x2 and EN_t=0x1, toggling EN and SRST, with a 16-cycle window -> TAINT_ACC matches the OR of the Q_t observed on the upstream model.
- ARM ignored:
  - ARM pulses during MONITOR and REPORT are ignored; the window length is unchanged.
  - A second report needs a fresh ARM in IDLE.
